btn_event_ctrl: RTL and testbench
=================================

Name: btn_event_ctrl

Overview:
Multi-button front-end controller that turns raw pushbutton pins into clean levels and single-cycle event pulses: press, release, long-press and auto-repeat. A shared prescaler sequences sampling for all channels. Per-channel filter counters and event FSMs sit between the board pins and the user-logic/UI layer.

Parameters:
NUM_BTNS, 5, number of independent button channels
TICK_DIV, 100_000, clk cycles per sample tick (1 ms at 100 MHz); >=2
STABLE_TICKS, 10, consecutive differing ticks needed to flip a debounced level; >=1
LONG_TICKS, 500, ticks held after press before long_evt; >=1
REPEAT_TICKS, 100, ticks between repeat_evt pulses after long_evt; 0 disables repeat

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
btn_raw  in  NUM_BTNS  asynchronous raw button pins, 1 = pressed
enable  in  1  controller enable; 0 = flush and idle
btn_level  out  NUM_BTNS  debounced level per channel
press_evt  out  NUM_BTNS  1-cycle pulse on debounced rising edge
release_evt  out  NUM_BTNS  1-cycle pulse on debounced falling edge
long_evt  out  NUM_BTNS  1-cycle pulse at long-press threshold
repeat_evt  out  NUM_BTNS  1-cycle pulse per repeat interval
tick  out  1  1-cycle sample strobe, for bench/visibility

Behaviour:
- One clock domain; reset is asynchronous and active-low. rst_n low: all outputs 0, all counters 0, all FSMs IDLE, synchronizers 0. Applies immediately, including mid-operation.
- Each btn_raw bit passes through a 2-FF synchronizer; only the synced value is used.
- Prescaler counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the count equals TICK_DIV-1. enable=0 holds the count at 0, so no ticks occur.
- Filter, per channel, evaluated only on tick:
  - synced != btn_level: filt_cnt++.
  - synced == btn_level: filt_cnt cleared.
  - filt_cnt reaching STABLE_TICKS: btn_level flips and filt_cnt clears, registered on that tick's edge.
- Latency from a clean raw edge to btn_level: 2 cycles + STABLE_TICKS ticks, +TICK_DIV cycles of phase uncertainty.
- All events are registered and asserted in the same cycle btn_level updates or the threshold is hit. Each lasts exactly 1 cycle.
- FSM per channel: IDLE, PRESSED, HELD.
  - IDLE: level rises -> press_evt, hold_cnt=0, go to PRESSED.
  - PRESSED: hold_cnt++ each tick. hold_cnt reaching LONG_TICKS -> long_evt, hold_cnt=0, go to HELD. Level falls -> release_evt, go to IDLE.
  - HELD: hold_cnt++ each tick. If REPEAT_TICKS>0 and hold_cnt reaches REPEAT_TICKS -> repeat_evt, hold_cnt=0. Level falls -> release_evt, go to IDLE.
- Simultaneous level-fall and threshold on the same tick: release wins; no long_evt or repeat_evt is issued.
- Channels are fully independent; any combination of channels may pulse in the same cycle.
- hold_cnt saturates and never wraps. It is sized $clog2(max(LONG_TICKS,REPEAT_TICKS)+1); filt_cnt is sized $clog2(STABLE_TICKS+1).
- enable falling:
  - Next edge: btn_level=0, all FSMs IDLE, counters 0.
  - No release_evt is generated for this flush.
  - When enable returns, a still-held button produces press_evt after STABLE_TICKS ticks.
- Elaboration-time assertions enforce parameter minimums.

Decomposition:
- Package btn_evt_pkg holds:
  - typedef enum logic [1:0] btn_state_t {IDLE, PRESSED, HELD};
  - default-parameter localparams.
- Sub-module btn_event_chan (synchronizer + filter + FSM for one channel) is instantiated NUM_BTNS times via generate.
- The prescaler stays in the top level, and its tick is fanned out to all channels.

Test Plan:
(TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=5, REPEAT_TICKS=2)
1. Assert rst_n=0 mid-hold with btn_level[0]=1 -> all outputs 0 in the same cycle; after release of reset, no events until new stimulus.
2. Hold btn_raw[0]=1 steady -> within 2+12..2+16 cycles btn_level[0]=1 and press_evt[0] pulses for exactly 1 cycle; other bits stay 0.
3. Toggle btn_raw[1] at 1-tick high / 1-tick low for 40 cycles -> btn_level[1] stays 0 and no events fire.
4. Hold btn_raw[2] -> press_evt; 5 ticks later long_evt; then repeat_evt every 2 ticks (8 cycles). Release -> release_evt after 3 ticks, with no further repeats.
5. Time a release so the debounced fall lands on the tick where hold_cnt reaches 5 -> release_evt only, no long_evt.
6. Drop enable with btn_raw[3] held -> btn_level[3]=0, no release_evt, tick stays 0. Re-enable -> press_evt[3] after 3 ticks.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared types and default parameter values for the button event controller.
// The per-channel FSM state type lives here so the top and the bench agree on encodings.
package btn_evt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    localparam int DEF_NUM_BTNS     = 5;
    localparam int DEF_TICK_DIV     = 100_000;
    localparam int DEF_STABLE_TICKS = 10;
    localparam int DEF_LONG_TICKS   = 500;
    localparam int DEF_REPEAT_TICKS = 100;

endpackage

// File: rtl/btn_event_chan.sv
// One button channel: 2-FF synchronizer, tick-driven debounce filter and the
// press/long/repeat/release event FSM. All outputs are registered.
module btn_event_chan
    import btn_evt_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw,
    input  logic       enable,
    input  logic       tick,
    output logic       level,
    output logic       press_evt,
    output logic       release_evt,
    output logic       long_evt,
    output logic       repeat_evt,
    output btn_state_t state
);

    localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HW       = $clog2(HOLD_MAX + 1);
    localparam int FW       = $clog2(STABLE_TICKS + 1);

    logic          sync1, sync2;
    logic [FW-1:0] filt_cnt, filt_next;
    logic [HW-1:0] hold_cnt, hold_next, hold_inc;
    btn_state_t    state_next;
    logic          level_next, press_next, release_next, long_next, repeat_next;
    logic          rise, fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            filt_cnt    <= '0;
            hold_cnt    <= '0;
            level       <= 1'b0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
            long_evt    <= 1'b0;
            repeat_evt  <= 1'b0;
        end else begin
            state       <= state_next;
            filt_cnt    <= filt_next;
            hold_cnt    <= hold_next;
            level       <= level_next;
            press_evt   <= press_next;
            release_evt <= release_next;
            long_evt    <= long_next;
            repeat_evt  <= repeat_next;
        end
    end

    // Saturating increment so a long hold with repeat disabled never wraps.
    assign hold_inc = (hold_cnt == {HW{1'b1}}) ? hold_cnt : hold_cnt + HW'(1);
    assign rise     = level_next & ~level;
    assign fall     = ~level_next & level;

    always_comb begin
        state_next   = state;
        filt_next    = filt_cnt;
        hold_next    = hold_cnt;
        level_next   = level;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;

        if (!enable) begin
            // Silent flush: no release event for a button held across disable.
            state_next = IDLE;
            filt_next  = '0;
            hold_next  = '0;
            level_next = 1'b0;
        end else if (tick) begin
            if (sync2 != level) begin
                if (filt_cnt == FW'(STABLE_TICKS - 1)) begin
                    level_next = ~level;
                    filt_next  = '0;
                end else begin
                    filt_next = filt_cnt + FW'(1);
                end
            end else begin
                filt_next = '0;
            end

            // A debounced fall takes priority over any hold threshold on the same tick.
            case (state)
                IDLE: begin
                    if (rise) begin
                        press_next = 1'b1;
                        hold_next  = '0;
                        state_next = PRESSED;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        release_next = 1'b1;
                        hold_next    = '0;
                        state_next   = IDLE;
                    end else if (hold_inc == HW'(LONG_TICKS)) begin
                        long_next  = 1'b1;
                        hold_next  = '0;
                        state_next = HELD;
                    end else begin
                        hold_next = hold_inc;
                    end
                end
                HELD: begin
                    if (fall) begin
                        release_next = 1'b1;
                        hold_next    = '0;
                        state_next   = IDLE;
                    end else if ((REPEAT_TICKS != 0) && (hold_inc == HW'(REPEAT_TICKS))) begin
                        repeat_next = 1'b1;
                        hold_next   = '0;
                    end else begin
                        hold_next = hold_inc;
                    end
                end
                default: begin
                    state_next = IDLE;
                    hold_next  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Multi-button front end: one shared sample-tick prescaler feeding NUM_BTNS
// independent debounce/event channels. chan_state packs each channel's FSM state.
module btn_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int NUM_BTNS     = DEF_NUM_BTNS,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_BTNS-1:0]   btn_raw,
    input  logic                  enable,
    output logic [NUM_BTNS-1:0]   btn_level,
    output logic [NUM_BTNS-1:0]   press_evt,
    output logic [NUM_BTNS-1:0]   release_evt,
    output logic [NUM_BTNS-1:0]   long_evt,
    output logic [NUM_BTNS-1:0]   repeat_evt,
    output logic                  tick,
    output logic [2*NUM_BTNS-1:0] chan_state
);

    if (NUM_BTNS < 1) begin : g_bad_num_btns
        $error("NUM_BTNS must be >= 1");
    end
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be >= 2");
    end
    if (STABLE_TICKS < 1) begin : g_bad_stable
        $error("STABLE_TICKS must be >= 1");
    end
    if (LONG_TICKS < 1) begin : g_bad_long
        $error("LONG_TICKS must be >= 1");
    end
    if (REPEAT_TICKS < 0) begin : g_bad_repeat
        $error("REPEAT_TICKS must be >= 0");
    end

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] pre_cnt;

    // Disabled controller parks the prescaler at 0 so no ticks are issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (!enable || (pre_cnt == PW'(TICK_DIV - 1))) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    assign tick = enable && (pre_cnt == PW'(TICK_DIV - 1));

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        btn_state_t st;

        btn_event_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw         (btn_raw[i]),
            .enable      (enable),
            .tick        (tick),
            .level       (btn_level[i]),
            .press_evt   (press_evt[i]),
            .release_evt (release_evt[i]),
            .long_evt    (long_evt[i]),
            .repeat_evt  (repeat_evt[i]),
            .state       (st)
        );

        assign chan_state[2*i +: 2] = st;
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: stimulus pushes expected events (kind, channel,
// tick index) into a queue; a negedge monitor pops and compares every event pulse.
module tb_btn_event_ctrl;

    localparam int NB = 5;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int LT = 5;
    localparam int RT = 2;
    localparam int W  = 21;

    localparam logic [1:0] K_PRESS = 2'd0;
    localparam logic [1:0] K_REL   = 2'd1;
    localparam logic [1:0] K_LONG  = 2'd2;
    localparam logic [1:0] K_REP   = 2'd3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NB-1:0]   btn_raw = '0;
    logic            enable = 1'b1;
    logic [NB-1:0]   btn_level, press_evt, release_evt, long_evt, repeat_evt;
    logic            tick;
    logic [2*NB-1:0] chan_state;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [15:0]  tick_cnt;

    logic [W-1:0] mon_got, mon_exp;
    logic         mon_hit;

    btn_event_ctrl #(
        .NUM_BTNS     (NB),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .LONG_TICKS   (LT),
        .REPEAT_TICKS (RT)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .enable      (enable),
        .btn_level   (btn_level),
        .press_evt   (press_evt),
        .release_evt (release_evt),
        .long_evt    (long_evt),
        .repeat_evt  (repeat_evt),
        .tick        (tick),
        .chan_state  (chan_state)
    );

    // Clock and reset-relative tick index
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_cnt <= '0;
        else if (tick) tick_cnt <= tick_cnt + 16'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Monitor: every event pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n) begin
            for (int ch = 0; ch < NB; ch++) begin
                for (int k = 0; k < 4; k++) begin
                    case (k)
                        0:       mon_hit = press_evt[ch];
                        1:       mon_hit = release_evt[ch];
                        2:       mon_hit = long_evt[ch];
                        default: mon_hit = repeat_evt[ch];
                    endcase
                    if (mon_hit) begin
                        mon_got = {2'(k), 3'(ch), tick_cnt};
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL evt_unexpected actual kind=%0d ch=%0d tick=%0d required none",
                                     mon_got[20:19], mon_got[18:16], mon_got[15:0]);
                        end else begin
                            mon_exp = exp_q.pop_front();
                            if (mon_got !== mon_exp) begin
                                errors++;
                                $display("FAIL evt_match actual kind=%0d ch=%0d tick=%0d required kind=%0d ch=%0d tick=%0d",
                                         mon_got[20:19], mon_got[18:16], mon_got[15:0],
                                         mon_exp[20:19], mon_exp[18:16], mon_exp[15:0]);
                            end
                        end
                    end
                end
            end
        end
    end

    // Driver and check helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_evt(input logic [1:0] kind, input int ch, input int t);
        exp_q.push_back({kind, 3'(ch), 16'(t)});
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Returns at a negedge inside a tick cycle; m is the tick index before that tick.
    task automatic align(output int m);
        int n = 0;
        @(negedge clk);
        while (!tick && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tick) begin
            checks++;
            errors++;
            $display("FAIL align actual=no_tick required=tick");
        end
        m = int'(tick_cnt);
    endtask

    task automatic wait_tick_at(input int target);
        int n = 0;
        @(negedge clk);
        while (!(tick && int'(tick_cnt) == target) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!(tick && int'(tick_cnt) == target)) begin
            checks++;
            errors++;
            $display("FAIL wait_tick actual=%0d required=%0d", tick_cnt, target);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        wait_cycles(10);
        check(name, exp_q.size(), 0);
    endtask

    // Directed sequence
    initial begin
        int m, q, lat, seen_tick, seen_lvl;

        wait_cycles(3);
        check("reset_level", btn_level, '0);
        check("reset_events", {press_evt, release_evt, long_evt, repeat_evt}, '0);
        check("reset_state", chan_state, '0);
        check("reset_tick", tick, 1'b0);
        rst_n = 1'b1;

        // Steady press on channel 0, then async reset mid-hold
        align(m);
        btn_raw[0] = 1'b1;
        expect_evt(K_PRESS, 0, m + 4);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!btn_level[0] && lat < 40);
        check("press_latency_window", (lat >= 12 && lat <= 18), 1'b1);
        check("ch0_level_only", btn_level, 5'b00001);
        wait_tick_at(m + 6);
        check("ch0_held_before_reset", btn_level[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_level", btn_level, '0);
        check("async_reset_events", {press_evt, release_evt, long_evt, repeat_evt}, '0);
        check("async_reset_tick", tick, 1'b0);
        btn_raw = '0;
        wait_cycles(3);
        check("async_reset_state", chan_state, '0);
        rst_n = 1'b1;
        wait_cycles(40);
        check("post_reset_quiet", btn_level, '0);
        drain("q_after_reset");

        // Channel 1 bounces every tick and never settles
        align(m);
        seen_lvl = 0;
        for (int i = 0; i < 5; i++) begin
            btn_raw[1] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (btn_level[1]) seen_lvl = 1;
            end
            btn_raw[1] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (btn_level[1]) seen_lvl = 1;
            end
        end
        wait_cycles(20);
        check("bounce_level_never_high", seen_lvl, 0);
        check("bounce_level_final", btn_level, '0);
        drain("q_after_bounce");

        // Channel 2: press, long, repeats, release cancels the coincident repeat
        align(m);
        btn_raw[2] = 1'b1;
        expect_evt(K_PRESS, 2, m + 4);
        expect_evt(K_LONG,  2, m + 9);
        expect_evt(K_REP,   2, m + 11);
        expect_evt(K_REP,   2, m + 13);
        expect_evt(K_REP,   2, m + 15);
        wait_tick_at(m + 13);
        check("ch2_state_held", chan_state[5:4], 2'd2);
        btn_raw[2] = 1'b0;
        expect_evt(K_REL, 2, m + 17);
        drain("q_after_long_repeat");
        check("ch2_state_idle", chan_state[5:4], 2'd0);

        // Channel 4: debounced fall lands on the long-press threshold tick
        align(m);
        btn_raw[4] = 1'b1;
        expect_evt(K_PRESS, 4, m + 4);
        wait_tick_at(m + 5);
        btn_raw[4] = 1'b0;
        expect_evt(K_REL, 4, m + 9);
        drain("q_after_release_race");

        // Channel 3: disable flushes silently, re-enable re-detects the held button
        align(m);
        btn_raw[3] = 1'b1;
        expect_evt(K_PRESS, 3, m + 4);
        wait_tick_at(m + 6);
        enable = 1'b0;
        @(negedge clk);
        check("flush_level", btn_level, '0);
        check("flush_state", chan_state, '0);
        seen_tick = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (tick) seen_tick = 1;
        end
        check("disabled_no_tick", seen_tick, 0);
        q = int'(tick_cnt);
        enable = 1'b1;
        expect_evt(K_PRESS, 3, q + 3);
        wait_tick_at(q + 3);
        check("reenable_level", btn_level[3], 1'b1);
        btn_raw[3] = 1'b0;
        expect_evt(K_REL, 3, q + 7);
        drain("q_after_enable");

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
